// File: rtl/rl_md_pkg.sv
// Shared defaults and tag layout for the MD force pipeline blocks.
// A tag travels alongside a pair through the force pipeline: {valid, ref_id, nb_id}.
package rl_md_pkg;

    localparam int DATA_WIDTH_DEF        = 32;
    localparam int PARTICLE_ID_WIDTH_DEF = 20;
    localparam int PIPE_LATENCY_DEF      = 17;
    localparam int CNT_WIDTH_DEF         = 8;

    typedef struct packed {
        logic                             valid;
        logic [PARTICLE_ID_WIDTH_DEF-1:0] ref_id;
        logic [PARTICLE_ID_WIDTH_DEF-1:0] nb_id;
    } tag_t;

    // Flat width of a tag for an arbitrary ID width, same field order as tag_t.
    function automatic int tag_width(input int id_width);
        return 1 + 2 * id_width;
    endfunction

endpackage

// File: rtl/rl_tag_delay_line.sv
// Fixed-latency, never-stalling shift register that carries pair tags
// in lockstep with the force pipeline.
module rl_tag_delay_line
    import rl_md_pkg::*;
#(
    parameter int DEPTH = PIPE_LATENCY_DEF,
    parameter int WIDTH = tag_width(PARTICLE_ID_WIDTH_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] tail_data
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: the whole stage array is reset, not only the valid bits, so a
    // reset in mid-flight leaves no stale IDs that could leak out later.
    // NOTE: non-blocking assignments let every stage read its neighbour's
    // old value, which is what makes this a shift register and not a wire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail_data = stage[DEPTH-1];

endmodule

// File: rtl/rl_force_tag_aligner.sv
// Re-attaches particle IDs to force-pipeline results, tracks in-flight tags
// and signals when every force for a reference particle has been emitted.
module rl_force_tag_aligner
    import rl_md_pkg::*;
#(
    parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
    parameter int PARTICLE_ID_WIDTH = PARTICLE_ID_WIDTH_DEF,
    parameter int PIPE_LATENCY      = PIPE_LATENCY_DEF,
    parameter int CNT_WIDTH         = CNT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_tag_valid,
    input  logic [PARTICLE_ID_WIDTH-1:0] in_ref_particle_id,
    input  logic [PARTICLE_ID_WIDTH-1:0] in_neighbor_particle_id,
    input  logic                         in_force_valid,
    input  logic [DATA_WIDTH-1:0]        in_force_x,
    input  logic [DATA_WIDTH-1:0]        in_force_y,
    input  logic [DATA_WIDTH-1:0]        in_force_z,
    input  logic                         in_flush,
    output logic                         out_valid,
    output logic [PARTICLE_ID_WIDTH-1:0] out_ref_particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0] out_neighbor_particle_id,
    output logic [DATA_WIDTH-1:0]        out_force_x,
    output logic [DATA_WIDTH-1:0]        out_force_y,
    output logic [DATA_WIDTH-1:0]        out_force_z,
    output logic                         out_ref_done,
    output logic [PARTICLE_ID_WIDTH-1:0] out_ref_done_id,
    output logic [CNT_WIDTH-1:0]         out_inflight_count,
    output logic                         out_pipe_empty,
    output logic                         out_align_error
);

    localparam int IDW   = PARTICLE_ID_WIDTH;
    localparam int TAG_W = tag_width(PARTICLE_ID_WIDTH);

    logic [TAG_W-1:0]     head_tag;
    logic [TAG_W-1:0]     tail_tag;
    logic                 tail_valid;
    logic [IDW-1:0]       tail_ref;
    logic [IDW-1:0]       tail_nb;

    logic [CNT_WIDTH-1:0] inflight_cnt;
    logic [CNT_WIDTH-1:0] inflight_cnt_nxt;
    logic [IDW-1:0]       last_ref;
    logic                 have_ref;
    logic                 flush_pend;

    logic                 transfer;
    logic                 mismatch;
    logic                 ref_change_done;
    logic                 flush_ready;
    logic                 flush_done;

    // Idle slots carry all-zero tags so nothing but the valid bit matters downstream.
    assign head_tag = in_tag_valid ? {1'b1, in_ref_particle_id, in_neighbor_particle_id}
                                   : '0;

    rl_tag_delay_line #(
        .DEPTH (PIPE_LATENCY),
        .WIDTH (TAG_W)
    ) u_delay_line (
        .clk       (clk),
        .rst       (rst),
        .in_data   (head_tag),
        .tail_data (tail_tag)
    );

    assign tail_valid = tail_tag[TAG_W-1];
    assign tail_ref   = tail_tag[2*IDW-1:IDW];
    assign tail_nb    = tail_tag[IDW-1:0];

    assign transfer        = tail_valid & in_force_valid;
    assign mismatch        = tail_valid ^ in_force_valid;
    assign ref_change_done = transfer & have_ref & (tail_ref != last_ref);

    // A flush waits until the pipe is drained; if a ref-change pulse is being
    // issued on the same edge it simply stays pending one more cycle.
    assign flush_ready = flush_pend & (inflight_cnt == '0) & ~tail_valid & ~ref_change_done;
    assign flush_done  = flush_ready & have_ref;

    // NOTE: the default assignment first means every path drives the
    // next value, so no latch can be inferred here.
    always_comb begin
        inflight_cnt_nxt = inflight_cnt;
        unique case ({in_tag_valid, tail_valid})
            2'b10:   inflight_cnt_nxt = inflight_cnt + CNT_WIDTH'(1);
            2'b01:   inflight_cnt_nxt = inflight_cnt - CNT_WIDTH'(1);
            default: inflight_cnt_nxt = inflight_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_ref_particle_id      <= '0;
            out_neighbor_particle_id <= '0;
            out_force_x              <= '0;
            out_force_y              <= '0;
            out_force_z              <= '0;
        end else if (transfer) begin
            out_ref_particle_id      <= tail_ref;
            out_neighbor_particle_id <= tail_nb;
            out_force_x              <= in_force_x;
            out_force_y              <= in_force_y;
            out_force_z              <= in_force_z;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid       <= 1'b0;
            out_ref_done    <= 1'b0;
            out_ref_done_id <= '0;
            out_align_error <= 1'b0;
            inflight_cnt    <= '0;
            last_ref        <= '0;
            have_ref        <= 1'b0;
            flush_pend      <= 1'b0;
        end else begin
            out_valid       <= transfer;
            out_ref_done    <= ref_change_done | flush_done;
            out_align_error <= out_align_error | mismatch;
            inflight_cnt    <= inflight_cnt_nxt;

            if (ref_change_done || flush_done) begin
                out_ref_done_id <= last_ref;
            end

            if (transfer) begin
                last_ref <= tail_ref;
                have_ref <= 1'b1;
            end else if (flush_ready) begin
                have_ref <= 1'b0;
            end

            // A new flush request always wins, so back-to-back requests merge.
            if (in_flush) begin
                flush_pend <= 1'b1;
            end else if (flush_ready) begin
                flush_pend <= 1'b0;
            end
        end
    end

    assign out_inflight_count = inflight_cnt;
    assign out_pipe_empty     = (inflight_cnt == '0) & ~flush_pend;

endmodule

// File: tb/tb_rl_force_tag_aligner.sv
// Scoreboard bench for rl_force_tag_aligner: a driver issues tags and models
// the force pipeline, a negedge monitor pops expected outputs and done pulses.
module tb_rl_force_tag_aligner;

    localparam int L   = 17;
    localparam int IDW = 20;
    localparam int DW  = 32;
    localparam int CW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_tag_valid, in_force_valid, in_flush;
    logic [IDW-1:0] in_ref, in_nb;
    logic [DW-1:0]  fx, fy, fz;
    logic           out_valid, out_ref_done, out_pipe_empty, out_align_error;
    logic [IDW-1:0] out_ref, out_nb, out_done_id;
    logic [DW-1:0]  ox, oy, oz;
    logic [CW-1:0]  cnt;

    logic           t1_tv, t1_fv;
    logic [IDW-1:0] t1_ref, t1_nb;
    logic           t1_out_valid, t1_done, t1_empty, t1_err;
    logic [IDW-1:0] t1_oref, t1_onb, t1_done_id;
    logic [DW-1:0]  t1_ox, t1_oy, t1_oz;
    logic [CW-1:0]  t1_cnt;

    rl_force_tag_aligner #(
        .DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(IDW), .PIPE_LATENCY(L), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_tag_valid(in_tag_valid), .in_ref_particle_id(in_ref),
        .in_neighbor_particle_id(in_nb), .in_force_valid(in_force_valid),
        .in_force_x(fx), .in_force_y(fy), .in_force_z(fz), .in_flush(in_flush),
        .out_valid(out_valid), .out_ref_particle_id(out_ref),
        .out_neighbor_particle_id(out_nb), .out_force_x(ox), .out_force_y(oy),
        .out_force_z(oz), .out_ref_done(out_ref_done), .out_ref_done_id(out_done_id),
        .out_inflight_count(cnt), .out_pipe_empty(out_pipe_empty),
        .out_align_error(out_align_error)
    );

    rl_force_tag_aligner #(
        .DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(IDW), .PIPE_LATENCY(1), .CNT_WIDTH(CW)
    ) dut1 (
        .clk(clk), .rst(rst),
        .in_tag_valid(t1_tv), .in_ref_particle_id(t1_ref),
        .in_neighbor_particle_id(t1_nb), .in_force_valid(t1_fv),
        .in_force_x(32'h0), .in_force_y(32'h0), .in_force_z(32'h0), .in_flush(1'b0),
        .out_valid(t1_out_valid), .out_ref_particle_id(t1_oref),
        .out_neighbor_particle_id(t1_onb), .out_force_x(t1_ox), .out_force_y(t1_oy),
        .out_force_z(t1_oz), .out_ref_done(t1_done), .out_ref_done_id(t1_done_id),
        .out_inflight_count(t1_cnt), .out_pipe_empty(t1_empty),
        .out_align_error(t1_err)
    );

    typedef struct {
        logic [IDW-1:0] r;
        logic [IDW-1:0] n;
        logic [DW-1:0]  x, y, z;
    } exp_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic           with_out;
    } done_t;

    typedef struct {
        bit            v;
        logic [DW-1:0] x, y, z;
    } fs_t;

    exp_t           exp_q[$];
    done_t          done_q[$];
    fs_t            fs[1024];
    int             cyc;
    int             n_checks;
    int             n_errors;
    logic [IDW-1:0] m_last;
    bit             m_have;
    int             t1_outs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk_fx(input logic [IDW-1:0] r, input logic [IDW-1:0] n);
        return 32'h3f80_0000 | {16'h0, r[7:0], n[7:0]};
    endfunction

    // One clock cycle of stimulus; also plays the role of the force pipeline.
    task automatic drive(input bit tv, input logic [IDW-1:0] r, input logic [IDW-1:0] n,
                         input bit fl, input bit spur);
        exp_t  e;
        done_t d;
        in_tag_valid   = tv;
        in_ref         = tv ? r : '0;
        in_nb          = tv ? n : '0;
        in_flush       = fl;
        in_force_valid = fs[cyc].v | spur;
        fx             = fs[cyc].x;
        fy             = fs[cyc].y;
        fz             = fs[cyc].z;
        if (tv) begin
            if (m_have && r != m_last) begin
                d.id = m_last; d.with_out = 1'b1;
                done_q.push_back(d);
            end
            m_last = r;
            m_have = 1'b1;
            e = '{r, n, mk_fx(r, n), ~mk_fx(r, n), mk_fx(r, n) ^ 32'h5a5a_5a5a};
            exp_q.push_back(e);
            fs[cyc+L].v = 1'b1;
            fs[cyc+L].x = e.x;
            fs[cyc+L].y = e.y;
            fs[cyc+L].z = e.z;
        end
        if (fl) begin
            if (m_have) begin
                d.id = m_last; d.with_out = 1'b0;
                done_q.push_back(d);
            end
            m_have = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 1024; i++) begin
            fs[i].v = 1'b0; fs[i].x = '0; fs[i].y = '0; fs[i].z = '0;
        end
    endtask

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        exp_t  e;
        done_t d;
        if (rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", {63'h0, out_valid}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_ref_id", {44'h0, out_ref}, {44'h0, e.r});
                    check("out_nb_id",  {44'h0, out_nb},  {44'h0, e.n});
                    check("out_force_x", {32'h0, ox}, {32'h0, e.x});
                    check("out_force_y", {32'h0, oy}, {32'h0, e.y});
                    check("out_force_z", {32'h0, oz}, {32'h0, e.z});
                end
            end
            if (out_ref_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_ref_done", {63'h0, out_ref_done}, 64'h0);
                end else begin
                    d = done_q.pop_front();
                    check("ref_done_id", {44'h0, out_done_id}, {44'h0, d.id});
                    check("ref_done_with_out", {63'h0, out_valid}, {63'h0, d.with_out});
                    if (!d.with_out) check("ref_done_after_drain", 64'(exp_q.size()), 64'h0);
                end
            end
        end
        if (t1_out_valid) t1_outs++;
    end

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; m_have = 1'b0; m_last = '0; t1_outs = 0;
        clear_sched();
        rst = 1'b0;
        in_tag_valid = 1'b0; in_force_valid = 1'b0; in_flush = 1'b0;
        in_ref = '0; in_nb = '0; fx = '0; fy = '0; fz = '0;
        t1_tv = 1'b0; t1_fv = 1'b0; t1_ref = '0; t1_nb = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid",  {63'h0, out_valid}, 64'h0);
        check("rst_count",      {56'h0, cnt}, 64'h0);
        check("rst_pipe_empty", {63'h0, out_pipe_empty}, 64'h1);
        check("rst_align_err",  {63'h0, out_align_error}, 64'h0);
        check("rst_ref_done",   {63'h0, out_ref_done}, 64'h0);
        rst = 1'b1;

        // Single tag: latency and in-flight count
        drive(1'b1, 20'd5, 20'd9, 1'b0, 1'b0);
        for (int k = 1; k <= L; k++) begin
            check("lat_count", {56'h0, cnt}, 64'h1);
            check("lat_no_early_out", {63'h0, out_valid}, 64'h0);
            idle(1);
        end
        check("lat_out_valid", {63'h0, out_valid}, 64'h1);
        check("lat_count_after", {56'h0, cnt}, 64'h0);
        idle(1);
        check("lat_single_pulse", {63'h0, out_valid}, 64'h0);
        idle(2);

        // Back-to-back tags with a reference change
        for (int i = 0; i < 40; i++) drive(1'b1, 20'd3, 20'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)  drive(1'b1, 20'd4, 20'(100 + i), 1'b0, 1'b0);
        check("b2b_count_full", {56'h0, cnt}, 64'(L));
        idle(25);
        check("b2b_count_drained", {56'h0, cnt}, 64'h0);

        // Flush after two tags
        drive(1'b1, 20'd3, 20'd1, 1'b0, 1'b0);
        drive(1'b1, 20'd3, 20'd2, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        idle(3);
        check("flush_pending_not_empty", {63'h0, out_pipe_empty}, 64'h0);
        idle(25);
        check("flush_pipe_empty", {63'h0, out_pipe_empty}, 64'h1);
        check("flush_count", {56'h0, cnt}, 64'h0);

        // Force result with no matching tag
        idle(10);
        check("align_err_before", {63'h0, out_align_error}, 64'h0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        check("align_err_set", {63'h0, out_align_error}, 64'h1);
        idle(5);
        check("align_err_sticky", {63'h0, out_align_error}, 64'h1);

        // Reset with 8 tags in flight
        for (int i = 0; i < 8; i++) drive(1'b1, 20'd7, 20'(i), 1'b0, 1'b0);
        check("mid_count_before_rst", {56'h0, cnt}, 64'h8);
        rst = 1'b0;
        #2;
        check("async_rst_count", {56'h0, cnt}, 64'h0);
        check("async_rst_err", {63'h0, out_align_error}, 64'h0);
        exp_q.delete();
        done_q.delete();
        clear_sched();
        m_have = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        rst = 1'b1;
        idle(30);
        check("post_rst_count", {56'h0, cnt}, 64'h0);
        check("post_rst_empty", {63'h0, out_pipe_empty}, 64'h1);
        check("post_rst_err", {63'h0, out_align_error}, 64'h0);

        // Latency 1 instance: simultaneous tag-in and tail-out
        for (int i = 0; i <= 100; i++) begin
            t1_tv  = (i < 100);
            t1_fv  = (i >= 1);
            t1_ref = 20'd1;
            t1_nb  = 20'(i);
            @(posedge clk);
            #1;
            if (i < 100) check("l1_count_const", {56'h0, t1_cnt}, 64'h1);
        end
        t1_tv = 1'b0; t1_fv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("l1_count_end", {56'h0, t1_cnt}, 64'h0);
        check("l1_outputs", 64'(t1_outs), 64'd100);
        check("l1_align_err", {63'h0, t1_err}, 64'h0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        check("done_queue_drained", 64'(done_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rl_force_tag_aligner.md
RL_FORCE_TAG_ALIGNER -- requirements
Module: rl_force_tag_aligner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the force word width (IEEE single).
REQ-002 SHALL have parameter PARTICLE_ID_WIDTH, default 20, the particle ID width.
REQ-003 SHALL have parameter PIPE_LATENCY, default 17, the force-pipeline latency in cycles; legal range 1..255.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, the in-flight counter width; must satisfy 2^CNT_WIDTH > PIPE_LATENCY.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_tag_valid, input, 1, a pair entering the force pipeline this cycle.
REQ-008 SHALL have ports in_ref_particle_id and in_neighbor_particle_id, input, PARTICLE_ID_WIDTH each, the IDs of that pair.
REQ-009 SHALL have port in_force_valid, input, 1, the force pipeline result valid.
REQ-010 SHALL have ports in_force_x, in_force_y and in_force_z, input, DATA_WIDTH each, the force pipeline result.
REQ-011 SHALL have port in_flush, input, 1, a single-cycle pulse meaning no further pairs for the current reference particle.
REQ-012 SHALL have port out_valid, output, 1, an aligned result is present.
REQ-013 SHALL have ports out_ref_particle_id and out_neighbor_particle_id, output, PARTICLE_ID_WIDTH each.
REQ-014 SHALL have ports out_force_x, out_force_y and out_force_z, output, DATA_WIDTH each.
REQ-015 SHALL have port out_ref_done, output, 1, a pulse meaning all forces for out_ref_done_id have been emitted.
REQ-016 SHALL have port out_ref_done_id, output, PARTICLE_ID_WIDTH, the finished reference ID.
REQ-017 SHALL have port out_inflight_count, output, CNT_WIDTH, the number of tags in the delay line.
REQ-018 SHALL have port out_pipe_empty, output, 1, high when out_inflight_count==0 and no flush is pending.
REQ-019 SHALL have port out_align_error, output, 1, a sticky tag/force misalignment flag.

Function
REQ-020 SHALL implement a tag delay line of PIPE_LATENCY stages, each holding {valid, ref ID, neighbor ID}, that shifts every cycle and never stalls.
REQ-021 SHALL make a tag accepted at cycle t reach the tail at cycle t+PIPE_LATENCY.
REQ-022 SHALL, when the tail is valid and in_force_valid=1, register both IDs and all three forces and assert out_valid for exactly one cycle at t+PIPE_LATENCY+1.
REQ-023 SHALL, when the tail valid and in_force_valid differ, drop that entry, leave out_valid=0, and set out_align_error, which stays set until reset.
REQ-024 SHALL update out_inflight_count as +1 on in_tag_valid and -1 on a valid tail; simultaneous increment and decrement leave it unchanged.
REQ-025 SHALL hold last_ref and have_ref, and on each out_valid whose ref ID differs from last_ref with have_ref=1, pulse out_ref_done with out_ref_done_id=last_ref in the same cycle.
REQ-026 SHALL, on every out_valid, load last_ref with the emitted ref ID and set have_ref.
REQ-027 SHALL treat in_flush as a pending flag; the flush completes in the first cycle with count==0 and no tail-to-output transfer in progress.
REQ-028 SHALL, on flush completion with have_ref=1, pulse out_ref_done with last_ref one cycle later, then clear have_ref.
REQ-029 SHALL, on flush completion with have_ref=0, clear the pending flag and emit no pulse.
REQ-030 SHALL make a second in_flush while one is pending merge into the same pending flag.
REQ-031 SHALL never issue two out_ref_done pulses in one cycle; a flush completion coinciding with a REQ-025 pulse is deferred one cycle.

Reset
REQ-032 SHALL, while rst is low, asynchronously clear all tag valids, the counter, last_ref, have_ref, the pending flush, out_align_error and all outputs to 0, with out_pipe_empty=1.
REQ-033 SHALL discard every in-flight tag when reset is asserted mid-operation, and SHALL emit no out_ref_done after release.

Structure
REQ-034 SHALL take PIPE_LATENCY, PARTICLE_ID_WIDTH and DATA_WIDTH defaults from a shared package rl_md_pkg, which also holds a tag struct {valid, ref_id, nb_id}.
REQ-035 SHALL instantiate the delay line as one sub-module rl_tag_delay_line, parametrised by depth and width.

Verification
REQ-036 SHALL verify: one tag (ref 5, nb 9) at cycle 0 with PIPE_LATENCY=17, force valid at cycle 17 -> out_valid at cycle 18 with IDs 5/9, and count 1 during cycles 1..17.
REQ-037 SHALL verify: 40 back-to-back tags with ref 3, then ref 4 -> 40 outputs for ref 3, and out_ref_done id 3 on the first ref-4 output.
REQ-038 SHALL verify: in_flush at cycle 2 after tags at cycles 0..1 -> out_ref_done id 3 only after the second output, and out_pipe_empty=1 afterwards.
REQ-039 SHALL verify: in_force_valid at cycle 10 with no tail tag -> out_align_error=1 and no out_valid.
REQ-040 SHALL verify: reset asserted with 8 tags in flight -> count 0, no outputs and no done pulse after release.
REQ-041 SHALL verify: PIPE_LATENCY=1 with simultaneous tag-in and tail-out for 100 cycles -> count constant at 1.
